// File: rtl/iob_eth_rx_buf_ctrl.sv
// RX buffer controller: maps receiver byte writes into an in-order ring of
// 2 KiB frame slots, commits per-slot descriptors and handshakes the receiver.
module iob_eth_rx_buf_ctrl #(
  parameter  int NSLOTS = 4,
  localparam int SLOT_W = $clog2(NSLOTS)
) (
  input  logic              RX_CLK,
  input  logic              rst,
  input  logic              enable_i,
  input  logic              frame_done_i,
  output logic              rcv_ack_o,
  input  logic [10:0]       rx_addr_i,
  input  logic              rx_wr_i,
  input  logic              rx_crc_err_i,
  output logic [SLOT_W+10:0] buf_addr_o,
  output logic              buf_wr_o,
  output logic              desc_valid_o,
  output logic [SLOT_W-1:0] desc_slot_o,
  output logic [11:0]       desc_len_o,
  output logic              desc_err_o,
  input  logic              desc_pop_i,
  output logic [SLOT_W:0]   used_o,
  output logic [15:0]       drop_cnt_o
);

  // state | meaning
  // IDLE  | waiting for the first write or a bare frame_done
  // RECV  | frame accepted into wr_slot, writes forwarded
  // DROP  | frame rejected, writes suppressed until frame_done
  // ACK   | acknowledging receiver until frame_done_i falls
  typedef enum logic [1:0] {IDLE, RECV, DROP, ACK} state_t;

  localparam logic [SLOT_W:0] FULL    = (SLOT_W+1)'(NSLOTS);
  localparam logic [11:0]     LEN_MAX = 12'd2048;

  state_t              state_q, state_d;
  logic [SLOT_W-1:0]   wr_slot_q, wr_slot_d;
  logic [SLOT_W-1:0]   rd_slot_q, rd_slot_d;
  logic [SLOT_W:0]     used_q, used_d;
  logic [11:0]         len_q, len_d;
  logic [15:0]         drop_cnt_q, drop_cnt_d;
  logic                buf_wr_q, buf_wr_d;
  logic [SLOT_W+10:0]  buf_addr_q, buf_addr_d;
  logic [11:0]         len_mem_q [NSLOTS];
  logic [11:0]         len_mem_d [NSLOTS];
  logic                err_mem_q [NSLOTS];
  logic                err_mem_d [NSLOTS];
  logic                commit;
  logic                pop;
  logic                free;

  assign free = (used_q != FULL);
  assign pop  = desc_pop_i && (used_q != '0);

  always_comb begin
    state_d    = state_q;
    wr_slot_d  = wr_slot_q;
    rd_slot_d  = rd_slot_q;
    used_d     = used_q;
    len_d      = len_q;
    drop_cnt_d = drop_cnt_q;
    buf_wr_d   = 1'b0;
    buf_addr_d = buf_addr_q;
    len_mem_d  = len_mem_q;
    err_mem_d  = err_mem_q;
    commit     = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_wr_i) begin
          // the slot is claimed here; nothing later can re-route this frame
          if (enable_i && free) begin
            state_d    = RECV;
            buf_wr_d   = 1'b1;
            buf_addr_d = {wr_slot_q, rx_addr_i};
            len_d      = 12'd1;
          end else begin
            state_d = DROP;
          end
        end else if (frame_done_i) begin
          state_d = ACK;
        end
      end
      RECV: begin
        if (rx_wr_i) begin
          buf_wr_d   = 1'b1;
          buf_addr_d = {wr_slot_q, rx_addr_i};
          if (len_q != LEN_MAX) len_d = len_q + 12'd1;
        end
        if (frame_done_i) begin
          commit  = 1'b1;
          state_d = ACK;
        end
      end
      DROP: begin
        if (frame_done_i) begin
          state_d = ACK;
          if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
        end
      end
      ACK: begin
        if (!frame_done_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (commit) begin
      len_mem_d[wr_slot_q] = len_d;
      err_mem_d[wr_slot_q] = rx_crc_err_i;
      wr_slot_d            = wr_slot_q + 1'b1;
    end
    if (pop) rd_slot_d = rd_slot_q + 1'b1;

    case ({commit, pop})
      2'b10:   used_d = used_q + 1'b1;
      2'b01:   used_d = used_q - 1'b1;
      default: used_d = used_q;
    endcase
  end

  always_ff @(posedge RX_CLK or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_slot_q  <= '0;
      rd_slot_q  <= '0;
      used_q     <= '0;
      len_q      <= '0;
      drop_cnt_q <= '0;
      buf_wr_q   <= 1'b0;
      buf_addr_q <= '0;
      for (int i = 0; i < NSLOTS; i++) begin
        len_mem_q[i] <= '0;
        err_mem_q[i] <= 1'b0;
      end
    end else begin
      state_q    <= state_d;
      wr_slot_q  <= wr_slot_d;
      rd_slot_q  <= rd_slot_d;
      used_q     <= used_d;
      len_q      <= len_d;
      drop_cnt_q <= drop_cnt_d;
      buf_wr_q   <= buf_wr_d;
      buf_addr_q <= buf_addr_d;
      len_mem_q  <= len_mem_d;
      err_mem_q  <= err_mem_d;
    end
  end

  assign rcv_ack_o    = (state_q == ACK);
  assign buf_wr_o     = buf_wr_q;
  assign buf_addr_o   = buf_addr_q;
  assign desc_valid_o = (used_q != '0);
  assign desc_slot_o  = rd_slot_q;
  assign desc_len_o   = len_mem_q[rd_slot_q];
  assign desc_err_o   = err_mem_q[rd_slot_q];
  assign used_o       = used_q;
  assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_iob_eth_rx_buf_ctrl.sv
// Scoreboard bench for iob_eth_rx_buf_ctrl: expected buffer writes and
// descriptors are queued by the stimulus and checked by a negedge monitor.
module tb_iob_eth_rx_buf_ctrl;
  localparam int NSLOTS = 4;
  localparam int SLOT_W = 2;

  logic              RX_CLK;
  logic              rst;
  logic              enable_i;
  logic              frame_done_i;
  logic              rcv_ack_o;
  logic [10:0]       rx_addr_i;
  logic              rx_wr_i;
  logic              rx_crc_err_i;
  logic [SLOT_W+10:0] buf_addr_o;
  logic              buf_wr_o;
  logic              desc_valid_o;
  logic [SLOT_W-1:0] desc_slot_o;
  logic [11:0]       desc_len_o;
  logic              desc_err_o;
  logic              desc_pop_i;
  logic [SLOT_W:0]   used_o;
  logic [15:0]       drop_cnt_o;

  iob_eth_rx_buf_ctrl #(.NSLOTS(NSLOTS)) dut (
    .RX_CLK(RX_CLK), .rst(rst), .enable_i(enable_i), .frame_done_i(frame_done_i),
    .rcv_ack_o(rcv_ack_o), .rx_addr_i(rx_addr_i), .rx_wr_i(rx_wr_i),
    .rx_crc_err_i(rx_crc_err_i), .buf_addr_o(buf_addr_o), .buf_wr_o(buf_wr_o),
    .desc_valid_o(desc_valid_o), .desc_slot_o(desc_slot_o), .desc_len_o(desc_len_o),
    .desc_err_o(desc_err_o), .desc_pop_i(desc_pop_i), .used_o(used_o),
    .drop_cnt_o(drop_cnt_o)
  );

  initial RX_CLK = 1'b0;
  always #5 RX_CLK = ~RX_CLK;

  typedef struct packed {
    logic [1:0]  slot;
    logic [11:0] len;
    logic        err;
  } desc_t;

  logic [12:0] exp_wr_q[$];
  desc_t       exp_desc_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  int          m_used;
  logic [1:0]  m_wr, m_rd;
  logic [15:0] m_drop;

  logic [12:0] mon_a;
  desc_t       mon_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge RX_CLK) begin
    if (!rst) begin
      if (buf_wr_o) begin
        if (exp_wr_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_write: got addr 0x%0h expected no write", buf_addr_o);
        end else begin
          mon_a = exp_wr_q.pop_front();
          check("buf_addr", 32'(buf_addr_o), 32'(mon_a));
        end
      end
      if (desc_pop_i && desc_valid_o) begin
        if (exp_desc_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_desc: got slot %0d expected no descriptor", desc_slot_o);
        end else begin
          mon_d = exp_desc_q.pop_front();
          check("desc_slot", 32'(desc_slot_o), 32'(mon_d.slot));
          check("desc_len", 32'(desc_len_o), 32'(mon_d.len));
          check("desc_err", 32'(desc_err_o), 32'(mon_d.err));
        end
      end
    end
  end

  task automatic tick();
    @(posedge RX_CLK);
    #1;
  endtask

  task automatic check_state();
    check("used", 32'(used_o), 32'(m_used));
    check("drop_cnt", 32'(drop_cnt_o), 32'(m_drop));
    check("desc_valid", 32'(desc_valid_o), 32'(m_used != 0));
    check("desc_slot_now", 32'(desc_slot_o), 32'(m_rd));
  endtask

  // n writes at offsets 0..n-1, then frame_done and the ack handshake
  task automatic frame(input int n, input bit en_first, input bit en_rest,
                       input bit crc, input bit pop_at_done);
    bit accept;
    int len;
    accept = en_first && (m_used < NSLOTS);
    len = (n > 2048) ? 2048 : n;
    for (int i = 0; i < n; i++) begin
      enable_i  = (i == 0) ? en_first : en_rest;
      rx_wr_i   = 1'b1;
      rx_addr_i = 11'(i);
      if (accept) exp_wr_q.push_back({m_wr, 11'(i)});
      tick();
    end
    rx_wr_i      = 1'b0;
    frame_done_i = 1'b1;
    rx_crc_err_i = crc;
    desc_pop_i   = pop_at_done;
    tick();
    desc_pop_i   = 1'b0;
    if (pop_at_done && m_used > 0) begin
      m_used--;
      m_rd++;
    end
    if (n > 0) begin
      if (accept) begin
        exp_desc_q.push_back('{slot: m_wr, len: 12'(len), err: crc});
        m_wr++;
        m_used++;
      end else if (m_drop != 16'hFFFF) begin
        m_drop++;
      end
    end
    check("ack_rise", 32'(rcv_ack_o), 32'd1);
    check_state();
    // ack must hold while frame_done stays high; writes in ACK are ignored
    rx_wr_i = 1'b1;
    tick();
    rx_wr_i = 1'b0;
    check("ack_hold", 32'(rcv_ack_o), 32'd1);
    frame_done_i = 1'b0;
    rx_crc_err_i = 1'b0;
    enable_i     = 1'b1;
    tick();
    check("ack_fall", 32'(rcv_ack_o), 32'd0);
  endtask

  task automatic pop_one();
    desc_pop_i = 1'b1;
    tick();
    desc_pop_i = 1'b0;
    if (m_used > 0) begin
      m_used--;
      m_rd++;
    end
    check_state();
  endtask

  task automatic model_reset();
    m_used = 0; m_wr = '0; m_rd = '0; m_drop = '0;
    exp_desc_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, 32'(rcv_ack_o), 32'd0);
    check({tag, "_buf_wr"}, 32'(buf_wr_o), 32'd0);
    check({tag, "_buf_addr"}, 32'(buf_addr_o), 32'd0);
    check({tag, "_desc_valid"}, 32'(desc_valid_o), 32'd0);
    check({tag, "_desc_slot"}, 32'(desc_slot_o), 32'd0);
    check({tag, "_desc_len"}, 32'(desc_len_o), 32'd0);
    check({tag, "_desc_err"}, 32'(desc_err_o), 32'd0);
    check({tag, "_used"}, 32'(used_o), 32'd0);
    check({tag, "_drop"}, 32'(drop_cnt_o), 32'd0);
  endtask

  initial begin
    rst = 1'b1; enable_i = 1'b1; frame_done_i = 1'b0; rx_addr_i = '0;
    rx_wr_i = 1'b0; rx_crc_err_i = 1'b0; desc_pop_i = 1'b0;
    model_reset();
    tick(); tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // single 64-byte frame
    frame(64, 1, 1, 0, 0);
    check("single_len", 32'(desc_len_o), 32'd64);
    check("single_err", 32'(desc_err_o), 32'd0);

    // reset in the middle of a frame being received into slot 1
    for (int i = 0; i < 3; i++) begin
      rx_wr_i = 1'b1; rx_addr_i = 11'(i);
      exp_wr_q.push_back({m_wr, 11'(i)});
      tick();
    end
    rx_wr_i = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    check("midreset_wr_drained", 32'(exp_wr_q.size()), 32'd0);
    model_reset();
    tick();
    rst = 1'b0;
    tick();

    // fill the ring, overflow one frame, then wrap
    frame(5, 1, 1, 0, 0);
    frame(6, 1, 1, 0, 0);
    frame(7, 1, 1, 0, 0);
    frame(8, 1, 1, 0, 0);
    frame(4, 1, 1, 0, 0);
    pop_one();
    frame(9, 1, 1, 0, 0);
    check("wrap_used", 32'(used_o), 32'd4);
    pop_one();
    pop_one();

    // commit and pop on the same edge with used == 2
    frame(10, 1, 1, 0, 1);
    check("simul_used", 32'(used_o), 32'd2);

    frame(3, 1, 1, 1, 0);
    frame(2050, 1, 1, 0, 0);
    pop_one(); pop_one(); pop_one(); pop_one();
    pop_one();

    // frame_done with no writes: handshake only
    frame(0, 1, 1, 0, 0);

    // disabled at first write, enable raised mid-frame
    frame(6, 0, 1, 0, 0);

    // preload the drop counter near saturation
    force dut.drop_cnt_q = 16'hFFFD;
    tick();
    release dut.drop_cnt_q;
    m_drop = 16'hFFFD;
    frame(2, 0, 0, 0, 0);
    frame(2, 0, 0, 0, 0);
    frame(2, 0, 0, 0, 0);
    check("drop_sat", 32'(drop_cnt_o), 32'hFFFF);

    tick();
    check("wr_queue_empty", 32'(exp_wr_q.size()), 32'd0);
    check("desc_queue_empty", 32'(exp_desc_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
